// File: rtl/if_litebpu.sv
// Static IFU branch predictor: backward-taken branches, JALR rs1 via shared RF read port.
// `define LITEBPU_X1_FWD_EN adds a dedicated zero-latency x1 forwarding path (jalr_x1_val).
module if_litebpu #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_i_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [4:0]         dec_jalr_rs1_indx,
  input  logic [PC_SIZE-1:0] pc,
  input  logic               oitf_empty,
  input  logic               ir_empty,
  input  logic               ir_rd_wen,
  input  logic [4:0]         ir_rd_indx,
`ifdef LITEBPU_X1_FWD_EN
  input  logic [XLEN-1:0]    jalr_x1_val,
`endif
  output logic               rf_rd_req,
  input  logic               rf_rd_gnt,
  input  logic [XLEN-1:0]    rf_rd_data,
  input  logic               ifu_req_hsked,
  output logic               prdt_taken,
  output logic [PC_SIZE-1:0] prdt_op1,
  output logic [PC_SIZE-1:0] prdt_op2,
  output logic               bpu_wait
);

  typedef enum logic [1:0] {IDLE, WAIT_DEP, REQ, RDY} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] rs1_q;
  logic            capture;
  logic            rs1_x0, rs1_xn, ir_wr, xn_hzd, x1_wait, jalr_xn;

  assign rs1_x0 = (dec_jalr_rs1_indx == 5'd0);
  assign ir_wr  = ~ir_empty & ir_rd_wen;
  assign xn_hzd = ~oitf_empty | (ir_wr & (ir_rd_indx == dec_jalr_rs1_indx));

`ifdef LITEBPU_X1_FWD_EN
  logic rs1_x1, x1_hzd;
  assign rs1_x1  = (dec_jalr_rs1_indx == 5'd1);
  assign x1_hzd  = ~oitf_empty | (ir_wr & (ir_rd_indx == 5'd1));
  assign rs1_xn  = ~rs1_x0 & ~rs1_x1;
  assign x1_wait = rs1_x1 & x1_hzd;
`else
  // Without forwarding, x1 is just another register behind the RF read port
  assign rs1_xn  = ~rs1_x0;
  assign x1_wait = 1'b0;
`endif

  assign jalr_xn = dec_i_valid & dec_jalr & rs1_xn;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:     if (jalr_xn) state_nxt = xn_hzd ? WAIT_DEP : REQ;
      WAIT_DEP: if (!dec_i_valid) state_nxt = IDLE;
                else if (!xn_hzd) state_nxt = REQ;
      // A flush wins over a same-cycle grant, so the read data is dropped
      REQ:      if (!dec_i_valid) state_nxt = IDLE;
                else if (rf_rd_gnt) begin
                  state_nxt = RDY;
                  capture   = 1'b1;
                end
      RDY:      if (!dec_i_valid || ifu_req_hsked) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_rd_req <= 1'b0;
      rs1_q     <= '0;
    end else begin
      state     <= state_nxt;
      rf_rd_req <= (state_nxt == REQ);
      if (capture) rs1_q <= rf_rd_data;
    end
  end

  assign prdt_taken = dec_i_valid & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));
  assign prdt_op2   = dec_bjp_imm[PC_SIZE-1:0];

  always_comb begin
    prdt_op1 = pc;
    if (dec_jalr) begin
      if (rs1_x0) prdt_op1 = '0;
`ifdef LITEBPU_X1_FWD_EN
      else if (rs1_x1) prdt_op1 = jalr_x1_val[PC_SIZE-1:0];
`endif
      else prdt_op1 = rs1_q[PC_SIZE-1:0];
    end
  end

  assign bpu_wait = dec_i_valid & dec_jalr & (x1_wait | (rs1_xn & (state != RDY)));

endmodule

// File: tb/tb_if_litebpu.sv
// Bench for if_litebpu: vector table, random idle traffic and transaction-level JALR model.
module tb_if_litebpu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1_indx;
  logic [31:0] pc;
  logic        oitf_empty, ir_empty, ir_rd_wen;
  logic [4:0]  ir_rd_indx;
`ifdef LITEBPU_X1_FWD_EN
  logic [31:0] jalr_x1_val;
  localparam int MIN_XN = 2;
`else
  localparam int MIN_XN = 1;
`endif
  logic        rf_rd_req, rf_rd_gnt;
  logic [31:0] rf_rd_data;
  logic        ifu_req_hsked;
  logic        prdt_taken, bpu_wait;
  logic [31:0] prdt_op1, prdt_op2;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_data;

  if_litebpu #(.PC_SIZE(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_i_valid(dec_i_valid), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1_indx(dec_jalr_rs1_indx), .pc(pc),
    .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_rd_wen(ir_rd_wen), .ir_rd_indx(ir_rd_indx),
`ifdef LITEBPU_X1_FWD_EN
    .jalr_x1_val(jalr_x1_val),
`endif
    .rf_rd_req(rf_rd_req), .rf_rd_gnt(rf_rd_gnt), .rf_rd_data(rf_rd_data),
    .ifu_req_hsked(ifu_req_hsked),
    .prdt_taken(prdt_taken), .prdt_op1(prdt_op1), .prdt_op2(prdt_op2), .bpu_wait(bpu_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, jal, jalr, bxx, oitf;
    logic [31:0] imm, pcv;
    logic [4:0]  rs1;
    logic        taken;
    logic [31:0] op1;
    logic        bwait;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    dec_i_valid = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
    dec_bjp_imm = '0; dec_jalr_rs1_indx = '0; pc = '0;
    oitf_empty = 1'b1; ir_empty = 1'b1; ir_rd_wen = 1'b0; ir_rd_indx = '0;
    rf_rd_gnt = 1'b0; rf_rd_data = '0; ifu_req_hsked = 1'b0;
`ifdef LITEBPU_X1_FWD_EN
    jalr_x1_val = '0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One JALR xN transaction: hazard for h cycles, grant g cycles after req rises,
  // r RDY cycles before the IFU handshake. Expectations come from cycle indices.
  task automatic jalr_txn(input logic [4:0] rs1, input int h, input int g,
                          input logic [31:0] d, input int r, input int kind);
    int  n_cyc;
    bit  rdy;
    n_cyc = h + g + r + 3;
    for (int c = 0; c < n_cyc; c++) begin
      rdy = (c >= h + 2 + g);
      idle_in();
      dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1_indx = rs1;
      dec_bjp_imm = $urandom; pc = $urandom;
      if (c < h) begin
        if (kind == 0) oitf_empty = 1'b0;
        else begin ir_empty = 1'b0; ir_rd_wen = 1'b1; ir_rd_indx = rs1; end
      end else if ($urandom_range(0, 1) == 1) begin
        ir_empty = 1'b0; ir_rd_wen = 1'($urandom_range(0, 1)); ir_rd_indx = rs1 ^ 5'h10;
      end
      if (c == h + 1 + g) begin
        rf_rd_gnt = 1'b1; rf_rd_data = d;
      end else if (c <= h || rdy) begin
        rf_rd_gnt = 1'($urandom_range(0, 1)); rf_rd_data = $urandom;
      end
      ifu_req_hsked = rdy ? (c == n_cyc - 1) : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("txn c%0d wait", c), 32'(bpu_wait), 32'(!rdy));
      chk($sformatf("txn c%0d req", c), 32'(rf_rd_req), 32'((c >= h + 1) && (c <= h + 1 + g)));
      chk($sformatf("txn c%0d taken", c), 32'(prdt_taken), 32'd1);
      chk($sformatf("txn c%0d op2", c), prdt_op2, dec_bjp_imm);
      if (rdy) chk($sformatf("txn c%0d op1", c), prdt_op1, d);
      cyc();
    end
    last_data = d;
    idle_in();
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20,       32'h100, 5'd0, 1'b1, 32'h100, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h200, 5'd0, 1'b1, 32'h200, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10,       32'h200, 5'd0, 1'b0, 32'h200, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4,        32'h300, 5'd0, 1'b1, 32'h0,   1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40,       32'h400, 5'd0, 1'b0, 32'h400, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h500, 5'd0, 1'b0, 32'h500, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFF00, 32'h600, 5'd0, 1'b1, 32'h600, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h0,   5'd0, 1'b1, 32'h0,   1'b0};

    // Reset: registered state cleared, combinational outputs still follow inputs
    idle_in();
    rst_n = 1'b0;
    dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1_indx = 5'd5;
    #12;
    chk("reset req", 32'(rf_rd_req), 32'd0);
    chk("reset op1", prdt_op1, 32'd0);
    chk("reset wait", 32'(bpu_wait), 32'd1);
    idle_in();
    cyc();
    rst_n = 1'b1;
    last_data = '0;

    for (int i = 0; i < 8; i++) begin
      idle_in();
      dec_i_valid = vt[i].valid; dec_jal = vt[i].jal; dec_jalr = vt[i].jalr; dec_bxx = vt[i].bxx;
      oitf_empty = vt[i].oitf; dec_bjp_imm = vt[i].imm; pc = vt[i].pcv;
      dec_jalr_rs1_indx = vt[i].rs1;
      @(negedge clk);
      chk($sformatf("vec%0d taken", i), 32'(prdt_taken), 32'(vt[i].taken));
      chk($sformatf("vec%0d op1", i), prdt_op1, vt[i].op1);
      chk($sformatf("vec%0d op2", i), prdt_op2, vt[i].imm);
      chk($sformatf("vec%0d wait", i), 32'(bpu_wait), 32'(vt[i].bwait));
      chk($sformatf("vec%0d req", i), 32'(rf_rd_req), 32'd0);
      cyc();
    end

    jalr_txn(5'd5, 0, 2, 32'h8000, 1, 0);
    jalr_txn(5'd5, 3, 1, 32'h1234, 0, 1);

    // Flush in REQ with a grant in the same cycle: data must be dropped
    dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1_indx = 5'd5;
    @(negedge clk);
    chk("flush c0 wait", 32'(bpu_wait), 32'd1);
    cyc();
    dec_i_valid = 1'b0; rf_rd_gnt = 1'b1; rf_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("flush c1 req", 32'(rf_rd_req), 32'd1);
    cyc();
    rf_rd_gnt = 1'b0;
    @(negedge clk);
    chk("flush c2 req", 32'(rf_rd_req), 32'd0);
    chk("flush c2 op1", prdt_op1, last_data);
    cyc();
    dec_i_valid = 1'b1;
    @(negedge clk);
    chk("flush c3 wait", 32'(bpu_wait), 32'd1);
    dec_i_valid = 1'b0;
    cyc();

    // Reset during REQ abandons the read; a later grant must not be captured
    dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1_indx = 5'd7;
    cyc();
    @(negedge clk);
    chk("rstmid req", 32'(rf_rd_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid async req", 32'(rf_rd_req), 32'd0);
    idle_in();
    cyc();
    rst_n = 1'b1;
    dec_jalr = 1'b1; dec_jalr_rs1_indx = 5'd7; rf_rd_gnt = 1'b1; rf_rd_data = 32'hCAFE0001;
    @(negedge clk);
    chk("rstmid post req", 32'(rf_rd_req), 32'd0);
    cyc();
    rf_rd_gnt = 1'b0;
    @(negedge clk);
    chk("rstmid op1", prdt_op1, 32'd0);
    last_data = '0;
    idle_in();
    cyc();

`ifdef LITEBPU_X1_FWD_EN
    dec_i_valid = 1'b1; dec_jalr = 1'b1; dec_jalr_rs1_indx = 5'd1;
    jalr_x1_val = 32'h2000; oitf_empty = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("x1 c%0d wait", c), 32'(bpu_wait), 32'd1);
      chk($sformatf("x1 c%0d req", c), 32'(rf_rd_req), 32'd0);
      cyc();
    end
    oitf_empty = 1'b1;
    @(negedge clk);
    chk("x1 wait clear", 32'(bpu_wait), 32'd0);
    chk("x1 op1", prdt_op1, 32'h2000);
    chk("x1 req", 32'(rf_rd_req), 32'd0);
    idle_in();
    cyc();
`endif

    // Random traffic that never launches an RF read: pure combinational checks
    for (int i = 0; i < 200; i++) begin
      int          cls;
      logic [31:0] e_op1;
      idle_in();
      cls = $urandom_range(0, 3);
      dec_i_valid = 1'($urandom_range(0, 1));
      dec_jal = (cls == 1); dec_jalr = (cls == 2); dec_bxx = (cls == 3);
      dec_bjp_imm = $urandom; pc = $urandom;
      dec_jalr_rs1_indx = dec_i_valid ? 5'd0 : 5'($urandom_range(0, 31));
      oitf_empty = 1'($urandom_range(0, 1)); ir_empty = 1'($urandom_range(0, 1));
      ir_rd_wen = 1'($urandom_range(0, 1)); ir_rd_indx = 5'($urandom_range(0, 31));
      rf_rd_gnt = 1'($urandom_range(0, 1)); rf_rd_data = $urandom;
      ifu_req_hsked = 1'($urandom_range(0, 1));
`ifdef LITEBPU_X1_FWD_EN
      jalr_x1_val = $urandom;
`endif
      e_op1 = pc;
      if (cls == 2) begin
        if (dec_jalr_rs1_indx == 5'd0) e_op1 = 32'd0;
`ifdef LITEBPU_X1_FWD_EN
        else if (dec_jalr_rs1_indx == 5'd1) e_op1 = jalr_x1_val;
`endif
        else e_op1 = last_data;
      end
      @(negedge clk);
      chk($sformatf("rnd%0d taken", i), 32'(prdt_taken),
          32'(dec_i_valid && (cls == 1 || cls == 2 || (cls == 3 && dec_bjp_imm[31]))));
      chk($sformatf("rnd%0d op2", i), prdt_op2, dec_bjp_imm);
      if (cls != 0) chk($sformatf("rnd%0d op1", i), prdt_op1, e_op1);
      chk($sformatf("rnd%0d wait", i), 32'(bpu_wait), 32'd0);
      chk($sformatf("rnd%0d req", i), 32'(rf_rd_req), 32'd0);
      cyc();
    end

    for (int i = 0; i < 30; i++) begin
      jalr_txn(5'($urandom_range(MIN_XN, 31)), $urandom_range(0, 4), $urandom_range(0, 3),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_litebpu.md
IF_LITEBPU -- requirements
Module: if_litebpu

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, fetch PC width.
REQ-002 SHALL have parameter XLEN, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dec_i_valid  input  1  mini-decoded IR-stage instruction valid.
REQ-006 SHALL have ports dec_jal, dec_jalr, dec_bxx  input  1 each  mini-decode class flags, at most one set.
REQ-007 SHALL have port dec_bjp_imm  input  XLEN  sign-extended branch/jump offset.
REQ-008 SHALL have port dec_jalr_rs1_indx  input  5  JALR rs1 index.
REQ-009 SHALL have port pc  input  PC_SIZE  PC of the decoded instruction.
REQ-010 SHALL have ports oitf_empty, ir_empty, ir_rd_wen  input  1 each  hazard status: no outstanding long ops, IR empty, IR instruction writes rd.
REQ-011 SHALL have port ir_rd_indx  input  5  rd index of the IR instruction.
REQ-012 SHALL have port jalr_x1_val  input  XLEN  forwarded x1 value (present only with LITEBPU_X1_FWD_EN).
REQ-013 SHALL have ports rf_rd_req  output  1 / rf_rd_gnt  input  1 / rf_rd_data  input  XLEN  shared RF read-port handshake; data valid in the cycle gnt is high.
REQ-014 SHALL have port ifu_req_hsked  input  1  IFU consumed the current prediction.
REQ-015 SHALL have ports prdt_taken  output  1, prdt_op1  output  PC_SIZE, prdt_op2  output  PC_SIZE, bpu_wait  output  1.

Function
REQ-016 prdt_taken SHALL equal dec_i_valid & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1])) (static backward-taken).
REQ-017 prdt_op2 SHALL equal dec_bjp_imm[PC_SIZE-1:0]; target = op1+op2 computed outside.
REQ-018 prdt_op1 SHALL be pc for jal/bxx, 0 for jalr rs1=x0, x1 source for rs1=x1, latched rs1 register for rs1=xN; zero-latency for all but xN and hazarded x1.
REQ-019 x1 hazard SHALL be: ~oitf_empty | (~ir_empty & ir_rd_wen & ir_rd_indx==1); xN hazard identical with ir_rd_indx==dec_jalr_rs1_indx.
REQ-020 FSM states SHALL be IDLE, WAIT_DEP, REQ, RDY.
REQ-021 IDLE: on dec_i_valid & dec_jalr & rs1 xN -> WAIT_DEP if xN hazard else REQ.
REQ-022 WAIT_DEP -> REQ in the cycle after the hazard clears.
REQ-023 REQ: rf_rd_req=1 (registered, only in REQ); on rf_rd_gnt capture rf_rd_data into rs1 register and -> RDY.
REQ-024 RDY: prdt_op1 = rs1 register; on ifu_req_hsked -> IDLE.
REQ-025 bpu_wait SHALL equal dec_i_valid & dec_jalr & ((rs1==x1 & x1 hazard) | (rs1 xN & state!=RDY)).
REQ-026 dec_i_valid low (flush) in WAIT_DEP/REQ/RDY SHALL force IDLE next cycle and drop rf_rd_req; a grant in that same cycle is discarded.
REQ-027 ifu_req_hsked outside RDY SHALL not change state.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, rs1 register 0, rf_rd_req 0; combinational outputs follow inputs.
REQ-029 Reset mid-handshake SHALL abandon the read; no capture after release until a new REQ.

Configuration
REQ-030 Macro LITEBPU_X1_FWD_EN defined: x1 uses jalr_x1_val, zero-latency when no x1 hazard, bpu_wait while hazarded.
REQ-031 Macro undefined: jalr_x1_val absent; rs1=x1 handled exactly as xN through the FSM/RF read port.

Verification
REQ-032 jal, pc=0x100, imm=0x20 -> same cycle prdt_taken=1, op1=0x100, op2=0x20, bpu_wait=0.
REQ-033 bxx imm=0xFFFFFFF0 -> taken=1; imm=0x10 -> taken=0; op1=pc both.
REQ-034 jalr rs1=x5, no hazard, gnt 2 cycles after req, data=0x8000 -> wait high 4 cycles, then op1=0x8000, wait=0; hsked -> IDLE.
REQ-035 jalr rs1=x5, ir_rd_wen=1, ir_rd_indx=5 for 3 cycles -> WAIT_DEP, rf_rd_req stays 0 until hazard clears.
REQ-036 flush (dec_i_valid=0) in REQ with gnt same cycle -> IDLE, rs1 register unchanged, rf_rd_req=0 next cycle.
REQ-037 With macro, jalr rs1=x1, oitf_empty=0 then 1, jalr_x1_val=0x2000 -> wait while 0, then op1=0x2000 same cycle, no rf_rd_req.
